// File: rtl/tplatch_pkg.sv
// tplatch_pkg: shared constants and arithmetic helpers for the latch bank.
// Revision: 1.0
`default_nettype none

package tplatch_pkg;

  localparam int TPL_MODE_TRANSPARENT = 0;
  localparam int TPL_MODE_REGISTERED  = 1;

  // Ceiling log2, used to size the popcount of close strobes.
  function automatic int tpl_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Operands are zero-extended to 64 bits, so the sum cannot wrap for counters up to 32 bits.
  function automatic logic [63:0] tpl_sat_add(input logic [63:0] acc,
                                               input logic [63:0] inc,
                                               input logic [63:0] max_v);
    logic [63:0] sum;
    sum = acc + inc;
    return (sum > max_v) ? max_v : sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/m_tplatch_bank_lane.sv
// m_tplatch_lane: one synchronously emulated level-sensitive latch with close-edge strobe.
// Revision: 1.0
`default_nettype none

module m_tplatch_lane
  import tplatch_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               MODE        = TPL_MODE_TRANSPARENT,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             closed_o
);

  logic [WIDTH-1:0] h_q;
  logic [WIDTH-1:0] h_d;
  logic             ebd_q;

  always_comb begin
    h_d = en_i ? d_i : h_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q   <= RESET_VALUE;
      ebd_q <= 1'b0;
    end else begin
      h_q   <= h_d;
      ebd_q <= en_i;
    end
  end

  // Output is forced to the reset value for as long as reset is held, in both modes.
  generate
    if (MODE == TPL_MODE_TRANSPARENT) begin : g_transparent
      assign q_o = rst_i ? RESET_VALUE : (en_i ? d_i : h_q);
    end else begin : g_registered
      assign q_o = rst_i ? RESET_VALUE : h_q;
    end
  endgenerate

  assign closed_o = ebd_q & ~en_i & ~rst_i;

endmodule

`default_nettype wire

// File: rtl/m_tplatch_bank.sv
// m_tplatch_bank: LANES x WIDTH latch bank with close strobes and saturating close counter.
// Revision: 1.0 -- optional snapshot register enabled by TPLATCH_BANK_SNAPSHOT_EN.
`default_nettype none

module m_tplatch_bank
  import tplatch_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               LANES       = 4,
  parameter int               MODE        = TPL_MODE_TRANSPARENT,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               COUNT_W     = 8
) (
  input  logic                   MasterClock,
  input  logic                   Reset,
  input  logic [LANES*WIDTH-1:0] D,
  input  logic [LANES-1:0]       EB,
  input  logic                   ClearCount,
`ifdef TPLATCH_BANK_SNAPSHOT_EN
  input  logic                   Snap,
  output logic [LANES*WIDTH-1:0] SnapQ,
`endif
  output logic [LANES*WIDTH-1:0] Q,
  output logic [LANES-1:0]       Closed,
  output logic [COUNT_W-1:0]     CloseCount
);

  localparam int          N_W   = tpl_clog2(LANES + 1);
  localparam logic [63:0] C_MAX = (64'd1 << COUNT_W) - 64'd1;

  logic [N_W-1:0]     close_n;
  logic [COUNT_W-1:0] count_base;
  logic [COUNT_W-1:0] count_d;
  logic [COUNT_W-1:0] count_q;

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      m_tplatch_lane #(
        .WIDTH       (WIDTH),
        .MODE        (MODE),
        .RESET_VALUE (RESET_VALUE)
      ) u_lane (
        .clk_i    (MasterClock),
        .rst_i    (Reset),
        .en_i     (EB[l]),
        .d_i      (D[l*WIDTH +: WIDTH]),
        .q_o      (Q[l*WIDTH +: WIDTH]),
        .closed_o (Closed[l])
      );
    end
  endgenerate

  // Clear zeroes the base first, so closes in the same cycle still count.
  always_comb begin
    close_n = '0;
    for (int l = 0; l < LANES; l++) begin
      close_n = close_n + N_W'(Closed[l]);
    end
    count_base = ClearCount ? '0 : count_q;
    count_d    = COUNT_W'(tpl_sat_add(64'(count_base), 64'(close_n), C_MAX));
  end

  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign CloseCount = count_q;

`ifdef TPLATCH_BANK_SNAPSHOT_EN
  logic [LANES*WIDTH-1:0] snap_q;

  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      snap_q <= {LANES{RESET_VALUE}};
    end else if (Snap) begin
      snap_q <= Q;
    end
  end

  assign SnapQ = snap_q;
`endif

endmodule

`default_nettype wire
